// File: rtl/prv_trap_sequencer_if.sv
// Trap-sequencer bus: exception/interrupt/mret notifications in, CSR strobes and redirect out.
// master = pipeline/CSR side, slave = the sequencer.
interface prv_trap_sequencer_if #(
  parameter int WORD_W = 32
);
  logic              fault_insn_page;
  logic              fault_insn;
  logic              illegal_insn;
  logic              mal_insn;
  logic              env;
  logic              breakpoint;
  logic              mal_l;
  logic              mal_s;
  logic              fault_load_page;
  logic              fault_store_page;
  logic              fault_l;
  logic              fault_s;
  logic              intr;
  logic [3:0]        intr_cause;
  logic              mret;
  logic              mem_stall;
  logic [WORD_W-1:0] epc;
  logic [WORD_W-1:0] badaddr;
  logic [WORD_W-1:0] mtvec;
  logic [WORD_W-1:0] mepc;

  logic              insert_pc;
  logic [WORD_W-1:0] priv_pc;
  logic              trap_busy;
  logic              csr_trap_we;
  logic [WORD_W-1:0] mepc_wdata;
  logic [WORD_W-1:0] mcause_wdata;
  logic [WORD_W-1:0] mtval_wdata;
  logic              csr_mret_we;

  modport master (
    output fault_insn_page, fault_insn, illegal_insn, mal_insn, env, breakpoint,
           mal_l, mal_s, fault_load_page, fault_store_page, fault_l, fault_s,
           intr, intr_cause, mret, mem_stall, epc, badaddr, mtvec, mepc,
    input  insert_pc, priv_pc, trap_busy, csr_trap_we, mepc_wdata, mcause_wdata,
           mtval_wdata, csr_mret_we
  );

  modport slave (
    input  fault_insn_page, fault_insn, illegal_insn, mal_insn, env, breakpoint,
           mal_l, mal_s, fault_load_page, fault_store_page, fault_l, fault_s,
           intr, intr_cause, mret, mem_stall, epc, badaddr, mtvec, mepc,
    output insert_pc, priv_pc, trap_busy, csr_trap_we, mepc_wdata, mcause_wdata,
           mtval_wdata, csr_mret_we
  );
endinterface

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap sequencer: captures one exception/interrupt/mret, waits out the memory
// stage, fires the CSR update strobe, then a one-cycle redirect to the trap/return target.
module prv_trap_sequencer #(
  parameter int WORD_W      = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input logic                CLK,
  input logic                RST,
  prv_trap_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_MEM = 2'd1, COMMIT = 2'd2, REDIRECT = 2'd3} state_t;
  typedef enum logic [1:0] {EV_EXC = 2'd0, EV_INTR = 2'd1, EV_MRET = 2'd2} kind_t;

  localparam logic [WORD_W-1:0] ALIGN_MASK = {{(WORD_W-2){1'b1}}, 2'b00};

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [3:0]        vec_cause_q, vec_cause_d;
  logic [WORD_W-1:0] cap_mepc_q, cap_mepc_d;
  logic [WORD_W-1:0] cap_mcause_q, cap_mcause_d;
  logic [WORD_W-1:0] cap_mtval_q, cap_mtval_d;
  logic [WORD_W-1:0] mepc_wdata_q, mepc_wdata_d;
  logic [WORD_W-1:0] mcause_wdata_q, mcause_wdata_d;
  logic [WORD_W-1:0] mtval_wdata_q, mtval_wdata_d;
  logic [WORD_W-1:0] priv_pc_q, priv_pc_d;

  logic              exc_hit;
  logic [3:0]        exc_code;
  logic              event_hit;
  kind_t             ev_kind;
  logic [WORD_W-1:0] ev_mcause;
  logic [WORD_W-1:0] ev_mtval;
  logic [WORD_W-1:0] trap_base;
  logic [WORD_W-1:0] trap_target;

  logic              trap_we_c;
  logic              mret_we_c;
  logic              insert_c;
  logic              busy_c;

  function automatic logic tval_from_badaddr(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd15: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin : exc_select
    exc_hit  = 1'b1;
    exc_code = 4'd0;
    if      (bus.fault_insn_page)  exc_code = 4'd12;
    else if (bus.fault_insn)       exc_code = 4'd1;
    else if (bus.illegal_insn)     exc_code = 4'd2;
    else if (bus.mal_insn)         exc_code = 4'd0;
    else if (bus.env)              exc_code = 4'd11;
    else if (bus.breakpoint)       exc_code = 4'd3;
    else if (bus.mal_l)            exc_code = 4'd4;
    else if (bus.mal_s)            exc_code = 4'd6;
    else if (bus.fault_load_page)  exc_code = 4'd13;
    else if (bus.fault_store_page) exc_code = 4'd15;
    else if (bus.fault_l)          exc_code = 4'd5;
    else if (bus.fault_s)          exc_code = 4'd7;
    else                           exc_hit  = 1'b0;
  end

  always_comb begin : event_values
    event_hit = exc_hit | bus.mret | bus.intr;
    if (exc_hit)       ev_kind = EV_EXC;
    else if (bus.mret) ev_kind = EV_MRET;
    else               ev_kind = EV_INTR;
    if (exc_hit) ev_mcause = {{(WORD_W-4){1'b0}}, exc_code};
    else         ev_mcause = {1'b1, {(WORD_W-5){1'b0}}, bus.intr_cause};
    ev_mtval = (exc_hit && tval_from_badaddr(exc_code)) ? bus.badaddr : '0;
  end

  // Target is built from mtvec as seen during COMMIT; vectoring applies to interrupts only.
  always_comb begin : target_calc
    trap_base = bus.mtvec & ALIGN_MASK;
    if (VECTORED_EN && (kind_q == EV_INTR) && (bus.mtvec[1:0] == 2'b01))
      trap_target = trap_base + {{(WORD_W-6){1'b0}}, vec_cause_q, 2'b00};
    else
      trap_target = trap_base;
  end

  always_ff @(posedge CLK or posedge RST) begin : state_reg
    if (RST) begin
      state_q        <= IDLE;
      kind_q         <= EV_EXC;
      vec_cause_q    <= '0;
      cap_mepc_q     <= '0;
      cap_mcause_q   <= '0;
      cap_mtval_q    <= '0;
      mepc_wdata_q   <= '0;
      mcause_wdata_q <= '0;
      mtval_wdata_q  <= '0;
      priv_pc_q      <= '0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      vec_cause_q    <= vec_cause_d;
      cap_mepc_q     <= cap_mepc_d;
      cap_mcause_q   <= cap_mcause_d;
      cap_mtval_q    <= cap_mtval_d;
      mepc_wdata_q   <= mepc_wdata_d;
      mcause_wdata_q <= mcause_wdata_d;
      mtval_wdata_q  <= mtval_wdata_d;
      priv_pc_q      <= priv_pc_d;
    end
  end

  always_comb begin : next_state
    state_d        = state_q;
    kind_d         = kind_q;
    vec_cause_d    = vec_cause_q;
    cap_mepc_d     = cap_mepc_q;
    cap_mcause_d   = cap_mcause_q;
    cap_mtval_d    = cap_mtval_q;
    mepc_wdata_d   = mepc_wdata_q;
    mcause_wdata_d = mcause_wdata_q;
    mtval_wdata_d  = mtval_wdata_q;
    priv_pc_d      = priv_pc_q;
    case (state_q)
      IDLE: begin
        if (event_hit) begin
          kind_d       = ev_kind;
          vec_cause_d  = bus.intr_cause;
          cap_mepc_d   = bus.epc & ALIGN_MASK;
          cap_mcause_d = ev_mcause;
          cap_mtval_d  = ev_mtval;
          state_d      = bus.mem_stall ? WAIT_MEM : COMMIT;
        end
      end
      WAIT_MEM: begin
        if (!bus.mem_stall) state_d = COMMIT;
      end
      COMMIT: begin
        state_d   = REDIRECT;
        priv_pc_d = (kind_q == EV_MRET) ? bus.mepc : trap_target;
      end
      default: state_d = IDLE;
    endcase
    // CSR write data changes only on entry to a trap COMMIT, so it holds between strobes.
    if ((state_d == COMMIT) && (state_q != COMMIT) && (kind_d != EV_MRET)) begin
      mepc_wdata_d   = cap_mepc_d;
      mcause_wdata_d = cap_mcause_d;
      mtval_wdata_d  = cap_mtval_d;
    end
  end

  always_comb begin : fsm_out
    trap_we_c = 1'b0;
    mret_we_c = 1'b0;
    insert_c  = 1'b0;
    busy_c    = (state_q != IDLE);
    case (state_q)
      COMMIT: begin
        if (kind_q == EV_MRET) mret_we_c = 1'b1;
        else                   trap_we_c = 1'b1;
      end
      REDIRECT: insert_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.insert_pc    = insert_c;
  assign bus.priv_pc      = priv_pc_q;
  assign bus.trap_busy    = busy_c;
  assign bus.csr_trap_we  = trap_we_c;
  assign bus.csr_mret_we  = mret_we_c;
  assign bus.mepc_wdata   = mepc_wdata_q;
  assign bus.mcause_wdata = mcause_wdata_q;
  assign bus.mtval_wdata  = mtval_wdata_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Bench for prv_trap_sequencer: a transaction-level model checked every cycle on a vectored
// and a direct-mode instance, plus hand-computed literal checks on directed scenarios.
module tb_prv_trap_sequencer;

  logic CLK;
  logic RST;

  prv_trap_sequencer_if #(.WORD_W(32)) bi ();
  prv_trap_sequencer_if #(.WORD_W(32)) bi2 ();

  prv_trap_sequencer #(.WORD_W(32), .VECTORED_EN(1'b1)) u_vec (.CLK(CLK), .RST(RST), .bus(bi));
  prv_trap_sequencer #(.WORD_W(32), .VECTORED_EN(1'b0)) u_dir (.CLK(CLK), .RST(RST), .bus(bi2));

  assign bi2.fault_insn_page  = bi.fault_insn_page;
  assign bi2.fault_insn       = bi.fault_insn;
  assign bi2.illegal_insn     = bi.illegal_insn;
  assign bi2.mal_insn         = bi.mal_insn;
  assign bi2.env              = bi.env;
  assign bi2.breakpoint       = bi.breakpoint;
  assign bi2.mal_l            = bi.mal_l;
  assign bi2.mal_s            = bi.mal_s;
  assign bi2.fault_load_page  = bi.fault_load_page;
  assign bi2.fault_store_page = bi.fault_store_page;
  assign bi2.fault_l          = bi.fault_l;
  assign bi2.fault_s          = bi.fault_s;
  assign bi2.intr             = bi.intr;
  assign bi2.intr_cause       = bi.intr_cause;
  assign bi2.mret             = bi.mret;
  assign bi2.mem_stall        = bi.mem_stall;
  assign bi2.epc              = bi.epc;
  assign bi2.badaddr          = bi.badaddr;
  assign bi2.mtvec            = bi.mtvec;
  assign bi2.mepc             = bi.mepc;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Flag vector order is exception priority, highest in bit 11.
  localparam logic [11:0] F_PAGE_I = 12'h800, F_INSN = 12'h400, F_ILL = 12'h200, F_MAL_I = 12'h100,
                          F_ENV = 12'h080, F_BRK = 12'h040, F_MAL_L = 12'h020, F_MAL_S = 12'h010,
                          F_PAGE_L = 12'h008, F_PAGE_S = 12'h004, F_L = 12'h002, F_S = 12'h001;
  int       exc_codes[12] = '{12, 1, 2, 0, 11, 3, 4, 6, 13, 15, 5, 7};
  bit [15:0] tval_map = 16'hB0F3;

  task automatic set_flags(input logic [11:0] v);
    {bi.fault_insn_page, bi.fault_insn, bi.illegal_insn, bi.mal_insn, bi.env, bi.breakpoint,
     bi.mal_l, bi.mal_s, bi.fault_load_page, bi.fault_store_page, bi.fault_l, bi.fault_s} = v;
  endtask

  typedef struct {
    bit        busy, waiting, trap_we, mret_we, insert, is_mret, is_intr;
    bit [3:0]  cause;
    bit [31:0] mepc_c, mcause_c, mtval_c, mepc_w, mcause_w, mtval_w, priv_pc;
  } mdl_t;

  mdl_t m_vec, m_dir;

  function automatic mdl_t mdl_fire(input mdl_t m);
    mdl_t n = m;
    if (m.is_mret) n.mret_we = 1'b1;
    else begin
      n.trap_we  = 1'b1;
      n.mepc_w   = m.mepc_c;
      n.mcause_w = m.mcause_c;
      n.mtval_w  = m.mtval_c;
    end
    return n;
  endfunction

  // One clock of the transaction: accept, wait for memory, strobe, redirect, retire.
  function automatic mdl_t mdl_step(input mdl_t m, input bit vect);
    mdl_t      n = m;
    bit [11:0] fl;
    int        code;
    bit [31:0] base;
    fl = {bi.fault_insn_page, bi.fault_insn, bi.illegal_insn, bi.mal_insn, bi.env, bi.breakpoint,
          bi.mal_l, bi.mal_s, bi.fault_load_page, bi.fault_store_page, bi.fault_l, bi.fault_s};
    if (m.insert) begin
      n.insert = 1'b0;
      n.busy   = 1'b0;
    end else if (m.trap_we || m.mret_we) begin
      n.trap_we = 1'b0;
      n.mret_we = 1'b0;
      n.insert  = 1'b1;
      base = bi.mtvec & 32'hFFFF_FFFC;
      if (m.is_mret) n.priv_pc = bi.mepc;
      else if (vect && m.is_intr && bi.mtvec[1:0] == 2'b01) n.priv_pc = base + 32'(m.cause) * 32'd4;
      else n.priv_pc = base;
    end else if (m.waiting) begin
      if (!bi.mem_stall) begin
        n.waiting = 1'b0;
        n = mdl_fire(n);
      end
    end else if (fl != 12'h000 || bi.mret || bi.intr) begin
      n.busy    = 1'b1;
      n.cause   = bi.intr_cause;
      n.is_mret = 1'b0;
      n.is_intr = 1'b0;
      code = -1;
      for (int i = 0; i < 12; i++) if (code < 0 && fl[11-i]) code = exc_codes[i];
      if (code >= 0) begin
        n.mcause_c = 32'(code);
        n.mtval_c  = tval_map[code] ? bi.badaddr : 32'h0;
      end else if (bi.mret) begin
        n.is_mret = 1'b1;
      end else begin
        n.is_intr  = 1'b1;
        n.mcause_c = 32'h8000_0000 | 32'(bi.intr_cause);
        n.mtval_c  = 32'h0;
      end
      n.mepc_c = bi.epc & 32'hFFFF_FFFC;
      if (bi.mem_stall) n.waiting = 1'b1;
      else n = mdl_fire(n);
    end
    return n;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_vec = '{default: 0};
      m_dir = '{default: 0};
    end else begin
      m_vec = mdl_step(m_vec, 1'b1);
      m_dir = mdl_step(m_dir, 1'b0);
    end
  end

  task automatic cmp_out(input string tag, input mdl_t m, input logic ins, input logic [31:0] ppc,
                         input logic busy, input logic twe, input logic mwe,
                         input logic [31:0] mw, input logic [31:0] cw, input logic [31:0] tw);
    chk({tag, ".insert_pc"},    {31'b0, ins},  {31'b0, m.insert});
    chk({tag, ".priv_pc"},      ppc,           m.priv_pc);
    chk({tag, ".trap_busy"},    {31'b0, busy}, {31'b0, m.busy});
    chk({tag, ".csr_trap_we"},  {31'b0, twe},  {31'b0, m.trap_we});
    chk({tag, ".csr_mret_we"},  {31'b0, mwe},  {31'b0, m.mret_we});
    chk({tag, ".mepc_wdata"},   mw,            m.mepc_w);
    chk({tag, ".mcause_wdata"}, cw,            m.mcause_w);
    chk({tag, ".mtval_wdata"},  tw,            m.mtval_w);
  endtask

  always @(negedge CLK) begin
    cmp_out("vec", m_vec, bi.insert_pc, bi.priv_pc, bi.trap_busy, bi.csr_trap_we, bi.csr_mret_we,
            bi.mepc_wdata, bi.mcause_wdata, bi.mtval_wdata);
    cmp_out("dir", m_dir, bi2.insert_pc, bi2.priv_pc, bi2.trap_busy, bi2.csr_trap_we, bi2.csr_mret_we,
            bi2.mepc_wdata, bi2.mcause_wdata, bi2.mtval_wdata);
  end

  task automatic idle_inputs();
    set_flags(12'h000);
    bi.intr = 1'b0;
    bi.mret = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    bi.intr_cause = 4'd0;
    bi.mem_stall  = 1'b0;
    bi.epc        = 32'h0;
    bi.badaddr    = 32'h0;
    bi.mtvec      = 32'h0;
    bi.mepc       = 32'h0;
    repeat (2) @(negedge CLK);
    chk("reset.busy", {31'b0, bi.trap_busy}, 32'h0);
    chk("reset.priv_pc", bi.priv_pc, 32'h0);
    chk("reset.mcause", bi.mcause_wdata, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    // Illegal instruction, direct trap into mtvec base.
    set_flags(F_ILL); bi.epc = 32'h0000_1006; bi.mtvec = 32'h8000_0001; bi.badaddr = 32'hDEAD_0000;
    @(negedge CLK); idle_inputs();
    chk("ill.trap_we", {31'b0, bi.csr_trap_we}, 32'h1);
    chk("ill.mcause", bi.mcause_wdata, 32'h2);
    chk("ill.mepc", bi.mepc_wdata, 32'h0000_1004);
    chk("ill.mtval", bi.mtval_wdata, 32'h0);
    @(negedge CLK);
    chk("ill.insert", {31'b0, bi.insert_pc}, 32'h1);
    chk("ill.priv_pc", bi.priv_pc, 32'h8000_0000);
    @(negedge CLK);

    // Vectored interrupt vs. direct-mode instance.
    bi.intr = 1'b1; bi.intr_cause = 4'd7; bi.epc = 32'h0000_2002;
    @(negedge CLK); idle_inputs();
    chk("intr.mcause", bi.mcause_wdata, 32'h8000_0007);
    chk("intr.mepc", bi.mepc_wdata, 32'h0000_2000);
    @(negedge CLK);
    chk("intr.priv_pc_vec", bi.priv_pc, 32'h8000_001C);
    chk("intr.priv_pc_dir", bi2.priv_pc, 32'h8000_0000);
    @(negedge CLK);

    // Two exceptions together under a three-cycle memory stall.
    set_flags(F_L | F_MAL_L); bi.badaddr = 32'h0000_2003; bi.mem_stall = 1'b1;
    @(negedge CLK); idle_inputs();
    chk("stall.busy0", {31'b0, bi.trap_busy}, 32'h1);
    chk("stall.we0", {31'b0, bi.csr_trap_we}, 32'h0);
    @(negedge CLK);
    chk("stall.we1", {31'b0, bi.csr_trap_we}, 32'h0);
    @(negedge CLK); bi.mem_stall = 1'b0;
    chk("stall.we2", {31'b0, bi.csr_trap_we}, 32'h0);
    @(negedge CLK);
    chk("stall.trap_we", {31'b0, bi.csr_trap_we}, 32'h1);
    chk("stall.mcause", bi.mcause_wdata, 32'h4);
    chk("stall.mtval", bi.mtval_wdata, 32'h0000_2003);
    @(negedge CLK);
    chk("stall.insert", {31'b0, bi.insert_pc}, 32'h1);
    @(negedge CLK);

    // mret outranks a simultaneous interrupt.
    bi.mret = 1'b1; bi.intr = 1'b1; bi.mepc = 32'h0000_4000;
    @(negedge CLK); idle_inputs();
    chk("mret.mret_we", {31'b0, bi.csr_mret_we}, 32'h1);
    chk("mret.trap_we", {31'b0, bi.csr_trap_we}, 32'h0);
    @(negedge CLK);
    chk("mret.insert", {31'b0, bi.insert_pc}, 32'h1);
    chk("mret.priv_pc", bi.priv_pc, 32'h0000_4000);
    @(negedge CLK);

    // mret target comes from mepc during the strobe cycle, not event time.
    bi.mret = 1'b1; bi.mepc = 32'h0000_3000;
    @(negedge CLK); idle_inputs(); bi.mepc = 32'h0000_5000;
    @(negedge CLK);
    chk("mret_late.priv_pc", bi.priv_pc, 32'h0000_5000);
    @(negedge CLK);

    // Second env while busy is dropped.
    set_flags(F_ENV); bi.epc = 32'h0000_0100;
    @(negedge CLK);
    chk("env.mcause", bi.mcause_wdata, 32'd11);
    @(negedge CLK); idle_inputs();
    chk("env.insert", {31'b0, bi.insert_pc}, 32'h1);
    @(negedge CLK);
    chk("env.no_second", {31'b0, bi.csr_trap_we}, 32'h0);
    @(negedge CLK);

    // Every exception alone, then all at once.
    for (int i = 0; i < 12; i++) begin
      set_flags(12'h800 >> i);
      bi.epc = 32'h0000_0103 + 32'(i) * 32'h10;
      bi.badaddr = 32'h0000_A000 + 32'(i);
      @(negedge CLK); idle_inputs();
      repeat (3) @(negedge CLK);
    end
    set_flags(12'hFFF); bi.badaddr = 32'h0000_BEEF;
    @(negedge CLK); idle_inputs();
    chk("all.mcause", bi.mcause_wdata, 32'd12);
    chk("all.mtval", bi.mtval_wdata, 32'h0000_BEEF);
    repeat (2) @(negedge CLK);

    // Reserved mtvec modes are direct; vectored offset wraps.
    bi.intr = 1'b1; bi.intr_cause = 4'd3; bi.mtvec = 32'h4000_0103;
    @(negedge CLK); idle_inputs();
    @(negedge CLK);
    chk("mode3.priv_pc", bi.priv_pc, 32'h4000_0100);
    @(negedge CLK);
    bi.intr = 1'b1; bi.intr_cause = 4'd15; bi.mtvec = 32'hFFFF_FFF1;
    @(negedge CLK); idle_inputs();
    @(negedge CLK);
    chk("wrap.priv_pc", bi.priv_pc, 32'h0000_002C);
    @(negedge CLK);

    // Asynchronous reset while waiting on memory.
    set_flags(F_BRK); bi.mem_stall = 1'b1;
    @(negedge CLK); idle_inputs();
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst.busy", {31'b0, bi.trap_busy}, 32'h0);
    chk("rst.priv_pc", bi.priv_pc, 32'h0);
    chk("rst.mcause", bi.mcause_wdata, 32'h0);
    @(negedge CLK); bi.mem_stall = 1'b0; RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      chk("rst.no_strobe", {29'b0, bi.csr_trap_we, bi.csr_mret_we, bi.insert_pc}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
